// File: rtl/ysyx_220053_div_ctrl.sv
// rtl/ysyx_220053_div_ctrl.sv - sequencer between the EX-stage ALU and the multi-cycle divider
//
// Takes one div/rem request at a time from EX and prepares the operands
// (W ops are extended from bits [31:0]). Zero-divisor and signed-overflow
// cases are resolved locally. All other requests run the valid/ready/out_valid
// handshake with ysyx_220053_divu. The final result is held until M/WB unblocks.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   req_valid/a/b/signed/     request from EX; operands stable while busy=1
//   word/rem
//   wb_block                  M/WB stalled, result must be held
//   flush                     kill the in-flight op
//   busy                      stall EX
//   res_valid, res            final result (res_valid only in HOLD)
//   div_valid, div_ready      request handshake to the divider
//   div_dividend/divisor/     prepared operands and mode to the divider
//   signed
//   div_flush                 abort the divider (one cycle, WAIT + flush)
//   div_out_valid, div_       divider result pulse and values
//   quotient/remainder

module ysyx_220053_div_ctrl #(
    parameter int XLEN           = 64,
    parameter bit BYPASS_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    input  logic            req_signed,
    input  logic            req_word,
    input  logic            req_rem,
    input  logic            wb_block,
    input  logic            flush,
    output logic            busy,
    output logic            res_valid,
    output logic [XLEN-1:0] res,
    output logic            div_valid,
    input  logic            div_ready,
    output logic [XLEN-1:0] div_dividend,
    output logic [XLEN-1:0] div_divisor,
    output logic            div_signed,
    output logic            div_flush,
    input  logic            div_out_valid,
    input  logic [XLEN-1:0] div_quotient,
    input  logic [XLEN-1:0] div_remainder
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Most negative value of a 64-bit op, and of a 32-bit op after sign extension.
    localparam logic [XLEN-1:0] MIN_D = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] MIN_W = {{(XLEN-31){1'b1}}, 31'b0};

    state_t          state;
    state_t          state_next;

    logic            word_q;
    logic            rem_q;

    logic [XLEN-1:0] prep_a;
    logic [XLEN-1:0] prep_b;
    logic            is_zero;
    logic            is_ovf;
    logic            is_special;
    logic [XLEN-1:0] spec_sel;
    logic [XLEN-1:0] div_sel;

    logic            accept;
    logic            res_load;
    logic [XLEN-1:0] res_next;

    // W results are always sign-extended from bit 31, including unsigned ops.
    function automatic logic [XLEN-1:0] fit_width(input logic word, input logic [XLEN-1:0] v);
        fit_width = word ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    // Operand preparation on the live request. The result is latched on acceptance.
    always_comb begin
        prep_a = req_a;
        prep_b = req_b;
        if (req_word) begin
            prep_a = {{(XLEN-32){req_signed & req_a[31]}}, req_a[31:0]};
            prep_b = {{(XLEN-32){req_signed & req_b[31]}}, req_b[31:0]};
        end
    end

    // Checks run on the prepared operands, so one compare covers both widths.
    // A signed W divisor of -1 extends to all ones.
    always_comb begin
        is_zero    = (prep_b == '0);
        is_ovf     = req_signed && (prep_b == '1) && (prep_a == (req_word ? MIN_W : MIN_D));
        is_special = BYPASS_SPECIAL && (is_zero || is_ovf);
        if (req_rem) begin
            spec_sel = is_zero ? prep_a : '0;
        end else begin
            spec_sel = is_zero ? '1 : prep_a;
        end
        div_sel = rem_q ? div_remainder : div_quotient;
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        res_load   = 1'b0;
        res_next   = res;
        busy       = 1'b0;
        res_valid  = 1'b0;
        div_valid  = 1'b0;
        div_flush  = 1'b0;
        case (state)
            IDLE: begin
                busy = req_valid & ~flush;
                if (req_valid && !flush) begin
                    accept = 1'b1;
                    if (is_special) begin
                        res_load   = 1'b1;
                        res_next   = fit_width(req_word, spec_sel);
                        state_next = HOLD;
                    end else begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                busy = 1'b1;
                // Withhold the request under flush so the divider cannot accept
                // an op that is being abandoned.
                div_valid = ~flush;
                if (flush) begin
                    state_next = IDLE;
                end else if (div_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                busy = 1'b1;
                if (flush) begin
                    div_flush  = 1'b1;
                    state_next = IDLE;
                end else if (div_out_valid) begin
                    res_load   = 1'b1;
                    res_next   = fit_width(word_q, div_sel);
                    state_next = HOLD;
                end
            end
            HOLD: begin
                res_valid = 1'b1;
                busy      = wb_block;
                if (flush || !wb_block) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_dividend <= '0;
            div_divisor  <= '0;
            div_signed   <= 1'b0;
            word_q       <= 1'b0;
            rem_q        <= 1'b0;
        end else if (accept) begin
            div_dividend <= prep_a;
            div_divisor  <= prep_b;
            div_signed   <= req_signed;
            word_q       <= req_word;
            rem_q        <= req_rem;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res <= '0;
        end else if (res_load) begin
            res <= res_next;
        end
    end

endmodule

// File: tb/tb_ysyx_220053_div_ctrl.sv
// tb/tb_ysyx_220053_div_ctrl.sv - self-checking bench for ysyx_220053_div_ctrl

module tb_ysyx_220053_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic [63:0] req_a = '0;
    logic [63:0] req_b = '0;
    logic        req_signed = 1'b0;
    logic        req_word = 1'b0;
    logic        req_rem = 1'b0;
    logic        wb_block = 1'b0;
    logic        flush = 1'b0;
    logic        busy;
    logic        res_valid;
    logic [63:0] res;
    logic        div_valid;
    logic        div_ready = 1'b0;
    logic [63:0] div_dividend;
    logic [63:0] div_divisor;
    logic        div_signed;
    logic        div_flush;
    logic        div_out_valid = 1'b0;
    logic [63:0] div_quotient = '0;
    logic [63:0] div_remainder = '0;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];
    logic [63:0] exp_v;

    ysyx_220053_div_ctrl #(.XLEN(64), .BYPASS_SPECIAL(1'b1)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_signed(req_signed), .req_word(req_word), .req_rem(req_rem),
        .wb_block(wb_block), .flush(flush),
        .busy(busy), .res_valid(res_valid), .res(res),
        .div_valid(div_valid), .div_ready(div_ready),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_signed(div_signed), .div_flush(div_flush),
        .div_out_valid(div_out_valid), .div_quotient(div_quotient),
        .div_remainder(div_remainder)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    // RISC-V M-extension reference result.
    function automatic logic [63:0] ref_div(input logic [63:0] a, input logic [63:0] b,
                                            input logic s, input logic w, input logic r);
        logic [31:0] a32, b32, q32, m32;
        logic [63:0] q64, m64;
        if (w) begin
            a32 = a[31:0];
            b32 = b[31:0];
            if (b32 == 32'd0) begin
                q32 = 32'hFFFF_FFFF; m32 = a32;
            end else if (s && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
                q32 = a32; m32 = 32'd0;
            end else if (s) begin
                q32 = $signed(a32) / $signed(b32); m32 = $signed(a32) % $signed(b32);
            end else begin
                q32 = a32 / b32; m32 = a32 % b32;
            end
            ref_div = r ? {{32{m32[31]}}, m32} : {{32{q32[31]}}, q32};
        end else begin
            if (b == 64'd0) begin
                q64 = '1; m64 = a;
            end else if (s && a == 64'h8000_0000_0000_0000 && b == '1) begin
                q64 = a; m64 = '0;
            end else if (s) begin
                q64 = $signed(a) / $signed(b); m64 = $signed(a) % $signed(b);
            end else begin
                q64 = a / b; m64 = a % b;
            end
            ref_div = r ? m64 : q64;
        end
    endfunction

    function automatic logic [63:0] prep(input logic [63:0] v, input logic s, input logic w);
        prep = w ? {{32{s & v[31]}}, v[31:0]} : v;
    endfunction

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_req(input logic [63:0] a, input logic [63:0] b,
                             input logic s, input logic w, input logic r);
        req_valid  = 1'b1;
        req_a      = a;
        req_b      = b;
        req_signed = s;
        req_word   = w;
        req_rem    = r;
    endtask

    // Divider stand-in: 64-bit core on the prepared operands.
    task automatic reply(input logic [63:0] dd, input logic [63:0] dv, input logic s);
        div_out_valid = 1'b1;
        if (s) begin
            div_quotient  = $signed(dd) / $signed(dv);
            div_remainder = $signed(dd) % $signed(dv);
        end else begin
            div_quotient  = dd / dv;
            div_remainder = dd % dv;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #2;
        checks++; if (res !== 64'd0) begin errors++; $display("FAIL reset_res got %h exp 0", res); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
        checks++; if (div_valid !== 1'b0 || div_flush !== 1'b0) begin errors++; $display("FAIL reset_div got v=%b f=%b exp 0 0", div_valid, div_flush); end
        checks++; if (busy !== 1'b0 || div_dividend !== 64'd0 || div_signed !== 1'b0) begin errors++; $display("FAIL reset_regs got busy=%b dd=%h s=%b exp 0", busy, div_dividend, div_signed); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_divu();
        drive_req(64'd100, 64'd7, 1'b0, 1'b0, 1'b0);
        div_ready = 1'b1;
        sb.push_back(ref_div(64'd100, 64'd7, 1'b0, 1'b0, 1'b0));
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL divu_busy_idle got %b exp 1", busy); end
        step();
        checks++; if (div_valid !== 1'b1 || div_dividend !== 64'd100 || div_divisor !== 64'd7 || div_signed !== 1'b0)
            begin errors++; $display("FAIL divu_issue got v=%b dd=%h dv=%h s=%b exp 1 64 7 0", div_valid, div_dividend, div_divisor, div_signed); end
        step();
        div_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            checks++; if (busy !== 1'b1 || div_valid !== 1'b0 || res_valid !== 1'b0)
                begin errors++; $display("FAIL divu_wait%0d got busy=%b v=%b rv=%b exp 1 0 0", i, busy, div_valid, res_valid); end
            if (i < 9) step();
        end
        reply(64'd100, 64'd7, 1'b0);
        step();
        div_out_valid = 1'b0;
        exp_v = sb.pop_front();
        checks++; if (res_valid !== 1'b1 || res !== exp_v) begin errors++; $display("FAIL divu_res got rv=%b res=%h exp 1 %h", res_valid, res, exp_v); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL divu_hold_busy got %b exp 0", busy); end
        req_valid = 1'b0;
        step();
        checks++; if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL divu_idle got rv=%b busy=%b exp 0 0", res_valid, busy); end
    endtask

    task automatic test_remw();
        logic [63:0] a, b;
        a = 64'hFFFF_FFFF_FFFF_FFF9;
        b = 64'd2;
        drive_req(a, b, 1'b1, 1'b1, 1'b1);
        div_ready = 1'b0;
        sb.push_back(ref_div(a, b, 1'b1, 1'b1, 1'b1));
        step();
        checks++; if (div_valid !== 1'b1 || div_dividend !== 64'hFFFF_FFFF_FFFF_FFF9 || div_divisor !== 64'd2 || div_signed !== 1'b1)
            begin errors++; $display("FAIL remw_issue got v=%b dd=%h dv=%h s=%b", div_valid, div_dividend, div_divisor, div_signed); end
        step();
        checks++; if (div_valid !== 1'b1) begin errors++; $display("FAIL remw_valid_hold got %b exp 1", div_valid); end
        div_ready = 1'b1;
        step();
        div_ready = 1'b0;
        checks++; if (div_valid !== 1'b0) begin errors++; $display("FAIL remw_valid_drop got %b exp 0", div_valid); end
        repeat (2) step();
        reply(prep(a, 1'b1, 1'b1), prep(b, 1'b1, 1'b1), 1'b1);
        step();
        div_out_valid = 1'b0;
        exp_v = sb.pop_front();
        checks++; if (res_valid !== 1'b1 || res !== exp_v) begin errors++; $display("FAIL remw_res got rv=%b res=%h exp 1 %h", res_valid, res, exp_v); end
        req_valid = 1'b0;
        step();
    endtask

    task automatic test_special();
        logic [63:0] ta[5] = '{64'd5, 64'h8000_0000_0000_0000, 64'h1234_5678_8000_0000, 64'hABCD_0000_8000_0001, 64'h8000_0000_0000_0000};
        logic [63:0] tb[5] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF};
        logic        ts[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        logic        tw[5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        tr[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            drive_req(ta[i], tb[i], ts[i], tw[i], tr[i]);
            sb.push_back(ref_div(ta[i], tb[i], ts[i], tw[i], tr[i]));
            #1;
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL special%0d_busy got %b exp 1", i, busy); end
            step();
            exp_v = sb.pop_front();
            checks++; if (div_valid !== 1'b0) begin errors++; $display("FAIL special%0d_div_valid got %b exp 0", i, div_valid); end
            checks++; if (res_valid !== 1'b1 || res !== exp_v) begin errors++; $display("FAIL special%0d_res got rv=%b res=%h exp 1 %h", i, res_valid, res, exp_v); end
            req_valid = 1'b0;
            step();
        end
    endtask

    task automatic test_back_to_back();
        drive_req(64'd9, 64'd0, 1'b0, 1'b0, 1'b1);
        wb_block = 1'b1;
        sb.push_back(ref_div(64'd9, 64'd0, 1'b0, 1'b0, 1'b1));
        step();
        exp_v = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            checks++; if (res_valid !== 1'b1 || res !== exp_v || busy !== 1'b1)
                begin errors++; $display("FAIL hold%0d got rv=%b res=%h busy=%b exp 1 %h 1", i, res_valid, res, busy, exp_v); end
            if (i < 4) step();
        end
        wb_block = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL release_busy got %b exp 0", busy); end
        step();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL release_idle got %b exp 0", res_valid); end
        drive_req(64'd1000, 64'd10, 1'b0, 1'b0, 1'b0);
        div_ready = 1'b1;
        sb.push_back(ref_div(64'd1000, 64'd10, 1'b0, 1'b0, 1'b0));
        step();
        checks++; if (div_valid !== 1'b1 || div_dividend !== 64'd1000) begin errors++; $display("FAIL b2b_issue got v=%b dd=%h exp 1 1000", div_valid, div_dividend); end
        step();
        div_ready = 1'b0;
        reply(64'd1000, 64'd10, 1'b0);
        step();
        div_out_valid = 1'b0;
        exp_v = sb.pop_front();
        checks++; if (res_valid !== 1'b1 || res !== exp_v) begin errors++; $display("FAIL b2b_res got rv=%b res=%h exp 1 %h", res_valid, res, exp_v); end
        req_valid = 1'b0;
        step();
    endtask

    task automatic test_flush();
        logic [63:0] prev;
        prev = res;
        drive_req(64'd50, 64'd5, 1'b0, 1'b0, 1'b0);
        div_ready = 1'b1;
        step();
        step();
        div_ready = 1'b0;
        flush = 1'b1;
        reply(64'd50, 64'd5, 1'b0);
        #1;
        checks++; if (div_flush !== 1'b1) begin errors++; $display("FAIL flush_pulse got %b exp 1", div_flush); end
        step();
        flush = 1'b0;
        div_out_valid = 1'b0;
        req_valid = 1'b0;
        #1;
        checks++; if (res_valid !== 1'b0 || div_flush !== 1'b0 || busy !== 1'b0)
            begin errors++; $display("FAIL flush_idle got rv=%b f=%b busy=%b exp 0 0 0", res_valid, div_flush, busy); end
        checks++; if (res !== prev) begin errors++; $display("FAIL flush_res_kept got %h exp %h", res, prev); end
        reply(64'd77, 64'd7, 1'b0);
        step();
        div_out_valid = 1'b0;
        checks++; if (res_valid !== 1'b0 || res !== prev) begin errors++; $display("FAIL idle_out_valid got rv=%b res=%h exp 0 %h", res_valid, res, prev); end
        drive_req(64'd3, 64'd0, 1'b0, 1'b0, 1'b0);
        wb_block = 1'b1;
        step();
        checks++; if (res_valid !== 1'b1 || res !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL flush_hold_res got rv=%b res=%h", res_valid, res); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        wb_block = 1'b0;
        req_valid = 1'b0;
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL flush_hold got %b exp 0", res_valid); end
        step();
    endtask

    task automatic test_rst_issue();
        drive_req(64'd81, 64'd9, 1'b1, 1'b0, 1'b0);
        div_ready = 1'b0;
        step();
        checks++; if (div_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_issue got %b exp 1", div_valid); end
        rst = 1'b1;
        #1;
        checks++; if (div_valid !== 1'b0 || div_flush !== 1'b0 || res_valid !== 1'b0)
            begin errors++; $display("FAIL rst_async got v=%b f=%b rv=%b exp 0 0 0", div_valid, div_flush, res_valid); end
        checks++; if (res !== 64'd0 || div_dividend !== 64'd0) begin errors++; $display("FAIL rst_regs got res=%h dd=%h exp 0 0", res, div_dividend); end
        req_valid = 1'b0;
        step();
        rst = 1'b0;
        step();
        checks++; if (busy !== 1'b0 || div_valid !== 1'b0) begin errors++; $display("FAIL rst_recover got busy=%b v=%b exp 0 0", busy, div_valid); end
    endtask

    initial begin
        test_reset();
        test_divu();
        test_remw();
        test_special();
        test_back_to_back();
        test_flush();
        test_rst_issue();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d exp 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_220053_div_ctrl.md
Name: ysyx_220053_div_ctrl

Overview:
Sequencer between the EX-stage ALU and the multi-cycle divider `ysyx_220053_divu`. It does four things:
- accepts one DIV/DIVU/REM/REMU (and W-variant) request at a time;
- prepares the operands and runs the divider's valid/ready/out_valid handshake;
- resolves RISC-V divide-by-zero and signed-overflow cases without launching the divider;
- holds the finished result until the M/WB stage unblocks.

It replaces the ad-hoc div_doing/old_div logic inside the ALU. It drives the ALU busy stall and the div/rem result mux input.

Parameters:
XLEN, 64, datapath width; only 64 is supported.
BYPASS_SPECIAL, 1, when 1, zero-divisor and overflow cases are resolved locally; when 0, every request goes to the divider.

Ports:
clk  in  1  clock
rst  in  1  reset; asynchronous, active-high
req_valid  in  1  EX holds a div/rem op; operands are stable while busy=1
req_a  in  64  dividend (rs1)
req_b  in  64  divisor (rs2)
req_signed  in  1  signed op
req_word  in  1  W-variant (32-bit op, sign-extended result)
req_rem  in  1  1 = remainder, 0 = quotient
wb_block  in  1  M/WB stalled; result must be held
flush  in  1  kill the in-flight op
busy  out  1  stall EX
res_valid  out  1  res holds the final result
res  out  64  final result
div_valid  out  1  divider request
div_ready  in  1  divider accepts
div_dividend  out  64  prepared dividend
div_divisor  out  64  prepared divisor
div_signed  out  1  divider signed mode
div_flush  out  1  abort the divider
div_out_valid  in  1  divider result valid (1-cycle pulse)
div_quotient  in  64  divider quotient
div_remainder  in  64  divider remainder

Behaviour:
- States: IDLE, ISSUE, WAIT, HOLD. Reset (async) forces IDLE.
- Reset values: res=0, res_valid=0, div_valid=0, div_flush=0, operand/control regs=0.
- Operand preparation, latched on acceptance:
  - req_word=0: operands pass through unchanged.
  - req_word=1: bits [31:0] extended to 64; sign-extended if req_signed, else zero-extended.
  - div_signed = latched req_signed.
- IDLE:
  - busy = req_valid & !flush.
  - Accept when req_valid & !flush.
  - Special case (BYPASS_SPECIAL=1) goes straight to HOLD; otherwise go to ISSUE.
- Special cases, evaluated on the prepared operands:
  - Prepared divisor == 0: quotient = all ones; remainder = prepared dividend.
  - Signed overflow, i.e. req_signed, divisor == -1 and dividend == most negative value of the op width: quotient = dividend, remainder = 0.
- ISSUE:
  - div_valid=1, busy=1.
  - div_valid stays high until div_ready is seen.
  - div_valid & div_ready → WAIT, with div_valid dropping the next cycle.
- WAIT:
  - busy=1, div_valid=0.
  - On div_out_valid: select quotient or remainder by req_rem, register into res, go to HOLD.
- Result width rule: for W ops, res = sign-extension of selected[31:0], for both signed and unsigned ops.
- HOLD:
  - res_valid=1, busy=wb_block.
  - res must not change while in HOLD.
  - The result is consumed in the cycle where wb_block=0; the next state is IDLE.
  - A new request is sampled in IDLE the next cycle: exactly one bubble between back-to-back divides.
- Latency:
  - Special case: res_valid the cycle after acceptance.
  - Normal: res_valid the cycle after div_out_valid.
- Flush, which has priority over every other event in the same cycle:
  - ISSUE → IDLE, div_valid=0.
  - WAIT → IDLE, with div_flush=1 for exactly that cycle. A div_out_valid in the same cycle is discarded.
  - HOLD → IDLE, res_valid=0 next cycle.
  - A div_out_valid arriving in IDLE is ignored.
- res_valid=0 in all states except HOLD. res keeps its last value outside HOLD.
- Asynchronous reset mid-operation returns to IDLE immediately with all outputs at reset values. The divider shares rst, so no div_flush is issued.

Test Plan:
- DIVU: a=100, b=7, div_ready=1, divider replies after 10 cycles with q=14, r=2 → busy high until the reply; res=14 and res_valid=1 the next cycle; IDLE after one unblocked cycle.
- REMW signed: a=0xFFFFFFFF_FFFFFFF9 (-7), b=2 → div_dividend=-7, div_signed=1; divider r=-1 → res=0xFFFFFFFFFFFFFFFF.
- DIV by zero: a=5, b=0 → div_valid never asserted; res=0xFFFFFFFFFFFFFFFF one cycle later.
- REM overflow, and DIVW overflow: REM with a=0x8000000000000000, b=-1 → res=0. DIVW with a[31:0]=0x80000000, b[31:0]=0xFFFFFFFF → res=0xFFFFFFFF80000000.
- wb_block=1 for 5 cycles in HOLD → res_valid, res and busy stable; release → IDLE next cycle, and a back-to-back request is issued on the following cycle.
- Flush in WAIT coincident with div_out_valid → div_flush pulse, no res_valid. Separately, rst asserted in ISSUE → IDLE immediately with div_valid=0.
